// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: ripple full-adder subtract of the divisor from
// the shifted partial remainder, keeping the difference only when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH-1:0] sub_b, diff;
  logic [WIDTH:0]   carry;

  assign sub_b    = ~divisor;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i]    = rem_in[i] ^ sub_b[i] ^ carry[i];
    assign carry[i+1] = (rem_in[i] & sub_b[i]) | (carry[i] & (rem_in[i] ^ sub_b[i]));
  end

  // Top stage subtracts the zero-extended divisor bit (inverted to 1): carry-out
  // here means no borrow, i.e. rem_in >= divisor.
  assign q_bit   = rem_in[WIDTH] | carry[WIDTH];
  assign rem_out = q_bit ? diff : rem_in[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle.
// Results are published on the edge leaving DONE and held until the next result.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;   // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, rem_q;
  logic             neg_q, neg_r, dbz_q;
  logic             accept, last_step, q_bit;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nxt;

  function automatic logic [WIDTH-1:0] twos(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign a_mag     = (is_signed && A[WIDTH-1]) ? twos(A) : A;
  assign b_mag     = (is_signed && B[WIDTH-1]) ? twos(B) : B;
  assign busy      = (state == CALC);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  ({rem_q, dvd_q[WIDTH-1]}),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (B == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      Quot        <= '0;
      Rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == DONE);
      // Sign correction happens as the result leaves DONE; the internal
      // registers may already be reloaded by a back-to-back start on this edge.
      if (state == DONE) begin
        Quot        <= neg_q ? twos(dvd_q) : dvd_q;
        Rem         <= neg_r ? twos(rem_q) : rem_q;
        div_by_zero <= dbz_q;
      end
      if (accept) begin
        cnt <= '0;
        if (B == '0) begin
          dvd_q <= '1;
          rem_q <= A;
          dvs_q <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          dbz_q <= 1'b1;
        end else begin
          dvd_q <= a_mag;
          rem_q <= '0;
          dvs_q <= b_mag;
          neg_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_r <= is_signed & A[WIDTH-1];
          dbz_q <= 1'b0;
        end
      end else if (state == CALC) begin
        cnt   <= cnt + CW'(1);
        rem_q <= rem_nxt;
        dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level behavioural model plus
// directed literal cases and randomized traffic.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] Quot, Rem;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .A(A), .B(B), .busy(busy), .done(done),
    .Quot(Quot), .Rem(Rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    int           due;
    logic [W-1:0] q, r;
    logic         z;
  } exp_t;

  exp_t         expq[$];
  exp_t         nx;
  int           cyc = 0, busy_till = 0;
  logic         e_done = 1'b0, e_busy = 1'b0, e_z = 1'b0;
  logic [W-1:0] e_q = '0, e_r = '0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    z = (b == '0);
    if (b == '0) begin
      q = '1; r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Model: an accepted start yields a result WIDTH+1 edges later (1 for /0);
  // the unit is busy for WIDTH cycles and refuses starts meanwhile.
  always begin
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      e_done = 1'b0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e_done = 1'b1; e_q = expq[0].q; e_r = expq[0].r; e_z = expq[0].z;
        void'(expq.pop_front());
      end
      if (start && cyc > busy_till) begin
        ref_div(A, B, is_signed, nx.q, nx.r, nx.z);
        nx.due    = cyc + ((B == '0) ? 1 : W + 1);
        busy_till = (B == '0) ? cyc : cyc + W;
        expq.push_back(nx);
      end
      e_busy = (cyc < busy_till);
    end
    @(negedge clk);
    if (!rst_n) begin
      expq.delete();
      busy_till = 0;
      e_done = 1'b0; e_busy = 1'b0; e_z = 1'b0; e_q = '0; e_r = '0;
    end
    check("done", done, e_done);
    check("busy", busy, e_busy);
    check("quot", Quot, e_q);
    check("rem", Rem, e_r);
    check("dbz", div_by_zero, e_z);
  end

  task automatic wait_done(input int poke, output int td, output int nb, output bit ok);
    ok = 0; nb = 0; td = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin ok = 1; td = cyc; break; end
      if (poke > 0) begin
        start = (i == poke);
        if (i == poke) begin A = 1000; B = 3; is_signed = 1'b0; end
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL timeout: no done within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] qx, input logic [W-1:0] rx, input logic zx,
                     input int poke);
    int t0, td, nb;
    bit ok;
    @(posedge clk); #2;
    start = 1'b1; is_signed = s; A = a; B = b;
    @(posedge clk); #1;
    t0 = cyc;
    #1;
    start = 1'b0; A = $urandom; B = $urandom; is_signed = 1'($urandom);
    wait_done(poke, td, nb, ok);
    if (ok) begin
      check("latency", td - t0, (b == '0) ? 1 : W + 1);
      check("busy_cycles", nb, (b == '0) ? 0 : W);
      check("lit_quot", Quot, qx);
      check("lit_rem", Rem, rx);
      check("lit_dbz", div_by_zero, zx);
    end
  endtask

  initial begin
    logic [W-1:0] mq, mr;
    logic         mz;
    int           t0, td, nb, nd;
    bit           ok;

    // Pin the reference model against hand-computed values.
    ref_div(32'd100, 32'd7, 1'b0, mq, mr, mz);
    check("model_u_q", mq, 32'd14);
    check("model_u_r", mr, 32'd2);
    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, mz);
    check("model_s_q", mq, 32'hFFFF_FFFD);
    check("model_s_r", mr, 32'hFFFF_FFFF);

    #12;
    check("rst_quot", Quot, 0);
    check("rst_rem", Rem, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    run(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);
    run(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    run(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    // Start pulsed mid-calculation must be ignored.
    run(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 5);

    // Reset at step 10 of an in-flight divide.
    @(posedge clk); #2;
    start = 1'b1; is_signed = 1'b0; A = 32'd123456; B = 32'd789;
    @(posedge clk); #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_quot", Quot, 0);
    check("abort_rem", Rem, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    run(1'b0, 32'd123456, 32'd789, 32'd156, 32'd372, 1'b0, 0);

    // Back-to-back: start held through DONE.
    @(posedge clk); #2;
    start = 1'b1; is_signed = 1'b0; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    t0 = cyc;
    #1;
    is_signed = 1'b1; A = 32'hFFFF_FFF9; B = 32'd2;
    wait_done(0, td, nb, ok);
    start = 1'b0;
    if (ok) begin
      check("b2b_lat1", td - t0, W + 1);
      check("b2b_quot1", Quot, 32'd14);
      check("b2b_rem1", Rem, 32'd2);
      t0 = td;
      wait_done(0, td, nb, ok);
      if (ok) begin
        check("b2b_lat2", td - t0, W + 1);
        check("b2b_quot2", Quot, 32'hFFFF_FFFD);
        check("b2b_rem2", Rem, 32'hFFFF_FFFF);
      end
    end

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      start     = ($urandom_range(0, 7) == 0);
      is_signed = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       begin A = $urandom; B = '0; end
        1:       begin A = 32'h8000_0000; B = 32'hFFFF_FFFF; end
        2:       begin A = $urandom; B = 32'($urandom_range(1, 15)); end
        3:       begin A = $urandom; B = ~32'($urandom_range(0, 14)); end
        4:       begin A = 32'($urandom_range(0, 255)); B = $urandom; end
        default: begin A = $urandom; B = $urandom; end
      endcase
    end
    @(posedge clk); #2 start = 1'b0;
    repeat (W + 5) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a divide; sampled only when accepted (IDLE or DONE state).
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement divide (DIV), 0 = unsigned divide (DIVU); sampled with start.
REQ-006 SHALL have port A  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port B  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a divide is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; Quot/Rem/div_by_zero valid.
REQ-010 SHALL have port Quot  output  WIDTH  quotient (MIPS LO).
REQ-011 SHALL have port Rem  output  WIDTH  remainder (MIPS HI).
REQ-012 SHALL have port div_by_zero  output  1  high with done when sampled B was zero.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-014 IDLE: start=1 with B!=0 SHALL load operands and go to CALC; start=1 with B==0 SHALL go to DONE; start=0 SHALL stay in IDLE.
REQ-015 Signed mode SHALL divide operand magnitudes; unsigned mode SHALL use operands unchanged.
REQ-016 CALC SHALL perform one restoring step per cycle: shift partial remainder left by one and bring in the next dividend bit (MSB first); WIDTH+1-bit trial subtract of divisor; if non-negative, keep the difference and set quotient bit 1, else keep the shifted remainder and set quotient bit 0.
REQ-017 CALC SHALL last exactly WIDTH cycles, counted by a clog2(WIDTH+1)-bit step counter, then go to DONE.
REQ-018 On entry to DONE, signed results SHALL be sign-corrected (truncation toward zero): quotient negated if A and B signs differ, remainder takes the sign of A.
REQ-019 DONE SHALL assert done for exactly one cycle, then go to IDLE; start=1 in DONE SHALL be accepted as in IDLE.
REQ-020 Latency: when start is accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH+1 (N+1 for divide by zero).
REQ-021 busy SHALL be high in every CALC cycle and low in IDLE and DONE.
REQ-022 start during CALC SHALL be ignored; the in-flight operation SHALL complete unaltered.
REQ-023 Divide by zero SHALL produce Quot = all ones, Rem = A, and div_by_zero=1, in both modes.
REQ-024 Signed most-negative / -1 SHALL produce Quot = most-negative value, Rem = 0, div_by_zero=0.
REQ-025 Quot, Rem and div_by_zero SHALL hold their values from done until the next done; they may change only on the edge that asserts done.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, busy=0, done=0, div_by_zero=0, Quot=0, Rem=0, counter=0.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; no done pulse for it SHALL follow.
REQ-028 The first start after reset release SHALL be handled normally.

Structure
REQ-029 Package div_pkg SHALL hold the FSM state type (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-030 The trial subtract SHALL be a combinational sub-module div_step (inputs: partial remainder, divisor; outputs: next remainder, quotient bit), built on the existing full-adder/subtract path.
REQ-031 Total RTL SHALL be 120-400 lines; no multiplier or "/" operator.

Verification
REQ-032 Unsigned: A=100, B=7 -> Quot=14, Rem=2, done exactly 33 cycles after the start edge, busy high for 32 cycles.
REQ-033 Signed: A=-7 (0xFFFFFFF9), B=2 -> Quot=0xFFFFFFFD, Rem=0xFFFFFFFF; the same operands unsigned -> Quot=0x7FFFFFFC, Rem=1.
REQ-034 Signed: A=0x80000000, B=0xFFFFFFFF -> Quot=0x80000000, Rem=0, div_by_zero=0.
REQ-035 Divide by zero: A=5, B=0 -> Quot=0xFFFFFFFF, Rem=5, div_by_zero=1, done one cycle after start.
REQ-036 Unsigned A=50, B=5; pulse start again with other operands during CALC; then assert rst_n low at CALC step 10 of a new divide -> the ignored start does not change the first result (Quot=10, Rem=0); after the reset all outputs are 0, no done appears, and the next divide completes correctly.
REQ-037 Back-to-back: start held high through DONE -> second divide accepted in the DONE cycle; its done arrives WIDTH+1 cycles later with correct results.
